// File: rtl/aidc_lite_comp_core_pkg.sv
// Shared types and sizing constants for the zero-word compaction core.
// Consumers: aidc_lite_comp_core_if, aidc_lite_comp_core.
package aidc_lite_comp_pkg;

  localparam int BLK_WORDS = 32;
  localparam int BUF_DEPTH = 16;
  localparam int BUF_AW    = 4;
  localparam int SIZE_W    = 6;
  localparam int MEM_AW    = $clog2(BLK_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_TAIL,
    ST_OUT
  } state_e;

endpackage

// File: rtl/aidc_lite_comp_core_if.sv
// Engine-side bus of the compaction core: start/ready, staging-buffer reads
// and the first-word-fall-through output port.
interface aidc_lite_comp_core_if;
  import aidc_lite_comp_pkg::*;

  logic              start_i;
  logic              ready_o;
  logic              buf_rden_o;
  logic [BUF_AW-1:0] buf_raddr_o;
  logic [63:0]       buf_rdata_i;
  logic              out_avail_o;
  logic [SIZE_W-1:0] size_o;
  logic              raw_o;
  logic              rden_i;
  logic [31:0]       rdata_o;

  modport slave (
    input  start_i, buf_rdata_i, rden_i,
    output ready_o, buf_rden_o, buf_raddr_o, out_avail_o, size_o, raw_o, rdata_o
  );

  modport master (
    output start_i, buf_rdata_i, rden_i,
    input  ready_o, buf_rden_o, buf_raddr_o, out_avail_o, size_o, raw_o, rdata_o
  );

endinterface

// File: rtl/aidc_lite_comp_core.sv
// Zero-word compaction of a 128-byte block: bitmap header plus non-zero words.
// Optional macro AIDC_LITE_COMP_RAW_FALLBACK_EN emits fully dense blocks raw.
//
//   state   | meaning
//   IDLE    | ready for start_i
//   SCAN    | reading staging entries 0..15
//   TAIL    | absorbing the last read datum, latching size
//   OUT     | compressed block available for popping
module aidc_lite_comp_core
  import aidc_lite_comp_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  aidc_lite_comp_core_if.slave bus
);

  state_e              state_q;
  logic                ready_q;
  logic                buf_rden_q;
  logic [BUF_AW-1:0]   buf_raddr_q;
  logic                rd_vld_q;
  logic [BUF_AW-1:0]   rd_idx_q;
  logic [BLK_WORDS-1:0] bitmap_q;
  logic [SIZE_W-1:0]   wr_ptr_q;
  logic [SIZE_W-1:0]   rd_ptr_q;
  logic [SIZE_W-1:0]   size_q;
  logic                out_avail_q;
  logic [31:0]         comp_mem [BLK_WORDS];
`ifdef AIDC_LITE_COMP_RAW_FALLBACK_EN
  logic                raw_q;
`endif

  logic [31:0]       lo_w, hi_w, rdata_d;
  logic              lo_nz, hi_nz, absorb;
  logic [SIZE_W-1:0] nz_add, nz_total;
  logic [MEM_AW-1:0] hi_idx, rd_m1;

  assign lo_w     = bus.buf_rdata_i[31:0];
  assign hi_w     = bus.buf_rdata_i[63:32];
  assign lo_nz    = (lo_w != 32'h0);
  assign hi_nz    = (hi_w != 32'h0);
  // Data returning after a reset or outside the scan window is dropped here.
  assign absorb   = rd_vld_q && (state_q == ST_SCAN || state_q == ST_TAIL);
  assign nz_add   = {{(SIZE_W-1){1'b0}}, lo_nz} + {{(SIZE_W-1){1'b0}}, hi_nz};
  assign nz_total = wr_ptr_q + (absorb ? nz_add : '0);
  assign hi_idx   = wr_ptr_q[MEM_AW-1:0] + {{(MEM_AW-1){1'b0}}, lo_nz};
  assign rd_m1    = rd_ptr_q[MEM_AW-1:0] - 1'b1;

  always_ff @(posedge clk) begin
    if (absorb) begin
      if (lo_nz) comp_mem[wr_ptr_q[MEM_AW-1:0]] <= lo_w;
      if (hi_nz) comp_mem[hi_idx] <= hi_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      buf_rden_q  <= 1'b0;
      buf_raddr_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      bitmap_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      size_q      <= '0;
      out_avail_q <= 1'b0;
`ifdef AIDC_LITE_COMP_RAW_FALLBACK_EN
      raw_q       <= 1'b0;
`endif
    end else begin
      rd_vld_q <= buf_rden_q;
      rd_idx_q <= buf_raddr_q;
      if (absorb) begin
        bitmap_q[{rd_idx_q, 1'b0}] <= lo_nz;
        bitmap_q[{rd_idx_q, 1'b1}] <= hi_nz;
        wr_ptr_q                   <= nz_total;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_q     <= ST_SCAN;
            ready_q     <= 1'b0;
            buf_rden_q  <= 1'b1;
            buf_raddr_q <= '0;
            bitmap_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            size_q      <= '0;
`ifdef AIDC_LITE_COMP_RAW_FALLBACK_EN
            raw_q       <= 1'b0;
`endif
          end
        end
        ST_SCAN: begin
          if (buf_raddr_q == BUF_AW'(BUF_DEPTH - 1)) begin
            buf_rden_q  <= 1'b0;
            buf_raddr_q <= '0;
            state_q     <= ST_TAIL;
          end else begin
            buf_raddr_q <= buf_raddr_q + 1'b1;
          end
        end
        ST_TAIL: begin
          state_q     <= ST_OUT;
          out_avail_q <= 1'b1;
`ifdef AIDC_LITE_COMP_RAW_FALLBACK_EN
          if (nz_total == SIZE_W'(BLK_WORDS)) begin
            size_q <= SIZE_W'(BLK_WORDS);
            raw_q  <= 1'b1;
          end else begin
            size_q <= nz_total + 1'b1;
          end
`else
          size_q      <= nz_total + 1'b1;
`endif
        end
        ST_OUT: begin
          if (bus.rden_i) begin
            if (rd_ptr_q == size_q - 1'b1) begin
              state_q     <= ST_IDLE;
              out_avail_q <= 1'b0;
              ready_q     <= 1'b1;
              rd_ptr_q    <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Word 0 is the bitmap header; payload word n lives at comp_mem[n-1].
  always_comb begin
    rdata_d = 32'h0;
    if (out_avail_q) begin
`ifdef AIDC_LITE_COMP_RAW_FALLBACK_EN
      if (raw_q)                rdata_d = comp_mem[rd_ptr_q[MEM_AW-1:0]];
      else if (rd_ptr_q == '0)  rdata_d = bitmap_q;
      else                      rdata_d = comp_mem[rd_m1];
`else
      if (rd_ptr_q == '0)       rdata_d = bitmap_q;
      else                      rdata_d = comp_mem[rd_m1];
`endif
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.buf_rden_o  = buf_rden_q;
  assign bus.buf_raddr_o = buf_raddr_q;
  assign bus.out_avail_o = out_avail_q;
  assign bus.size_o      = size_q;
  assign bus.rdata_o     = rdata_d;
`ifdef AIDC_LITE_COMP_RAW_FALLBACK_EN
  assign bus.raw_o       = raw_q;
`else
  assign bus.raw_o       = 1'b0;
`endif

endmodule

// File: tb/tb_aidc_lite_comp_core.sv
// Directed-vector bench for aidc_lite_comp_core; honours AIDC_LITE_COMP_RAW_FALLBACK_EN.
module tb_aidc_lite_comp_core;
  import aidc_lite_comp_pkg::*;

  logic clk;
  logic rst;
  aidc_lite_comp_core_if bus();

  aidc_lite_comp_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Staging buffer: data one cycle after the read enable.
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (bus.buf_rden_o) bus.buf_rdata_i <= mem[bus.buf_raddr_o];
  end

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          pat;
    logic [5:0]  size;
    logic        raw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    case (pat)
      1: mem[2]  = 64'hDEAD_BEEF_0000_0000;
      2: begin
        mem[3]  = 64'h1111_1111_0000_0000;
        mem[15] = 64'h0000_0000_2222_2222;
      end
      3: for (int i = 0; i < 16; i++) mem[i] = {32'(2*i + 2), 32'(2*i + 1)};
      4: begin
        mem[0]  = 64'h0000_0000_0000_0001;
        mem[15] = 64'h0000_0005_0000_0000;
      end
      5: mem[7]  = 64'hAAAA_0000_0000_BBBB;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] exp_word(input vec_t v, input int k);
    case (k)
      0:       return v.w0;
      1:       return v.w1;
      2:       return v.w2;
      default: return v.raw ? 32'(k + 1) : 32'(k);
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},     32'(bus.ready_o),     32'd1);
    chk({tag, "_buf_rden"},  32'(bus.buf_rden_o),  32'd0);
    chk({tag, "_buf_raddr"}, 32'(bus.buf_raddr_o), 32'd0);
    chk({tag, "_out_avail"}, 32'(bus.out_avail_o), 32'd0);
    chk({tag, "_size"},      32'(bus.size_o),      32'd0);
    chk({tag, "_raw"},       32'(bus.raw_o),       32'd0);
    chk({tag, "_rdata"},     bus.rdata_o,          32'd0);
  endtask

  task automatic run_block(input vec_t v, input bit mid_scan_noise, input bit start_on_last_pop,
                           input string tag);
    int n;
    fill(v.pat);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    n = 1;
    while (!bus.out_avail_o && n < 40) begin
      bus.start_i = (mid_scan_noise && n == 5);
      bus.rden_i  = (mid_scan_noise && (n == 6 || n == 7));
      tick();
      n++;
    end
    bus.start_i = 1'b0;
    bus.rden_i  = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'd18);
    chk({tag, "_size"}, 32'(bus.size_o), 32'(v.size));
    chk({tag, "_raw"},  32'(bus.raw_o),  32'(v.raw));
    for (int k = 0; k < int'(v.size); k++) begin
      chk($sformatf("%s_word%0d", tag, k), bus.rdata_o, exp_word(v, k));
      bus.rden_i  = 1'b1;
      bus.start_i = (start_on_last_pop && k == int'(v.size) - 1);
      tick();
      bus.rden_i  = 1'b0;
      bus.start_i = 1'b0;
    end
    chk({tag, "_avail_after"}, 32'(bus.out_avail_o), 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.ready_o),     32'd1);
    if (start_on_last_pop) begin
      tick();
      chk({tag, "_still_idle"},  32'(bus.ready_o),    32'd1);
      chk({tag, "_no_rden"},     32'(bus.buf_rden_o), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{pat: 0, size: 6'd1, raw: 1'b0, w0: 32'h0000_0000, w1: 32'h0, w2: 32'h0};
    vecs[1] = '{pat: 1, size: 6'd2, raw: 1'b0, w0: 32'h0000_0020, w1: 32'hDEAD_BEEF, w2: 32'h0};
    vecs[2] = '{pat: 2, size: 6'd3, raw: 1'b0, w0: 32'h4000_0080, w1: 32'h1111_1111,
                w2: 32'h2222_2222};
`ifdef AIDC_LITE_COMP_RAW_FALLBACK_EN
    vecs[3] = '{pat: 3, size: 6'd32, raw: 1'b1, w0: 32'h1, w1: 32'h2, w2: 32'h3};
`else
    vecs[3] = '{pat: 3, size: 6'd33, raw: 1'b0, w0: 32'hFFFF_FFFF, w1: 32'h1, w2: 32'h2};
`endif
    vecs[4] = '{pat: 4, size: 6'd3, raw: 1'b0, w0: 32'h8000_0001, w1: 32'h1, w2: 32'h5};
    vecs[5] = '{pat: 5, size: 6'd3, raw: 1'b0, w0: 32'h0000_C000, w1: 32'h0000_BBBB,
                w2: 32'hAAAA_0000};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.rden_i  = 1'b0;
    fill(0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < 6; i++) run_block(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    run_block(vecs[1], 1'b1, 1'b1, "start_ignored");

    fill(3);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("midscan_addr", 32'(bus.buf_raddr_o), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("midscan_rst");
    tick();
    run_block(vecs[2], 1'b0, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
